temporal_spike_encoder: RTL and testbench
=========================================

Name: temporal_spike_encoder

Overview:
- Upstream stage of the TNN column; drives the neuron `input_spikes` bus.
- Converts a vector of binary input values into temporally encoded spikes. Value v gives one pulse that starts v unit-clock cycles into the gamma wave.
- Each pulse is 2^WRES cycles wide, matching the neuron's [wmax+1]-cycle pulse encoding.
- A single-entry buffer with a valid/ready handshake decouples the producer from gamma timing.

Parameters:
- INP, 16: number of encoded inputs; equals the neuron synapse count.
- VRES, 3: value bit resolution; spike times are 0 to 2^VRES-1.
- WRES, 3: weight resolution of the downstream neuron; pulse width is 2^WRES cycles.

Ports:
- clk  in  1  unit clock for temporal encoding.
- rst  in  1  reset; synchronous, active-high; overrides all other inputs.
- grst  in  1  one-cycle gamma clock pulse; starts a new wave.
- in_data  in  [INP-1:0][VRES-1:0]  spike time per input.
- in_mask  in  INP  1 = input spikes this wave; 0 = null input, never spikes.
- in_valid  in  1  producer has a vector on in_data/in_mask.
- in_ready  out  1  encoder can accept a vector.
- spikes  out  INP  encoded spike pulses to the neuron.
- busy  out  1  a wave is in progress.
- underflow  out  1  one-cycle flag: grst found no buffered vector.

Behaviour:
- Reset (rst=1 at a clock edge), effective from the next cycle:
  - spikes=0, busy=0, underflow=0.
  - Buffer empty; active vector cleared; state IDLE.
  - in_ready is forced 0 combinationally while rst=1. Data offered during reset is discarded.
- Buffer:
  - in_ready = !buf_full; registered state only, no combinational path from grst or in_valid.
  - A transfer occurs when in_valid && in_ready. The buffer captures in_data and in_mask, and buf_full=1 next cycle.
- Gamma start (grst=1 at cycle G, rst=0):
  - If buf_full: the buffer moves into the active registers, buf_full=0 at G+1, state RUN, wave counter t=0 at G+1.
  - If the buffer is empty: active mask cleared (silent wave), underflow=1 at G+1 only, state IDLE, busy stays 0.
  - A transfer accepted in cycle G itself lands in the buffer for the next wave. There is no bypass, so this case counts as empty for the current grst.
- Wave counter: t increments by 1 each cycle in RUN. Counter width is VRES+WRES+1 bits; no wrap inside a wave.
- Spike output, registered: for active input i with mask=1 and value v, spikes[i]=1 exactly in cycles G+1+v through G+v+2^WRES. That is 2^WRES cycles, one pulse per wave. Masked inputs stay 0.
- busy:
  - busy=1 in cycles G+1 through G+2^VRES+2^WRES-1, independent of the mask or values.
  - State RUN goes to IDLE after the last of those cycles; t then holds and spikes=0.
- grst during RUN aborts the current wave. All spikes follow the new wave from G+1 with t restarting at 0; no pulse continues across grst.
  - If underflow results from that grst: spikes=0 and busy=0 from G+1.
- rst during RUN: outputs are in their reset values on the next cycle. An in-flight pulse is truncated.
- Simultaneous grst and a transfer with a full buffer: the buffer drains to active, and in_ready was 0, so no transfer occurs.
- States:
  - IDLE to RUN on grst with buffer full.
  - RUN to RUN (restart) on grst with buffer full.
  - RUN to IDLE on end of wave, or on grst with buffer empty.
  - Any state to IDLE on rst.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> spikes=0, busy=0, underflow=0, in_ready=0 during rst and 1 after; no vector is stored.
- Basic wave (INP=4, VRES=3, WRES=3): load values {0,3,7,5}, mask 4'b1111, then grst at cycle 10:
  - spikes[0] high in cycles 11-18, [1] 14-21, [2] 18-25, [3] 16-23.
  - busy high in cycles 11-25; all outputs 0 from cycle 26.
- Masking: same values with mask 4'b1010 -> only spikes[1] (14-21) and spikes[3] (16-23) pulse; busy still high 11-25.
- Underflow: grst with the buffer empty, and separately grst in the same cycle as a transfer:
  - underflow=1 for exactly one cycle, spikes stay 0, busy=0.
  - In the second case the vector is retained and used by the next grst.
- Abort: wave started at 10, next vector buffered, grst at cycle 15:
  - The old pulses drop at 16 unless the new wave drives them.
  - A new-wave input with v=0 is high in cycles 16-23; busy extends to cycle 30.
- Backpressure and reset mid-wave:
  - With the buffer full and in_valid held, in_ready=0 until the cycle after grst; the accept then occurs exactly once.
  - rst at cycle 14 of a running wave -> spikes, busy and the buffer are all cleared at cycle 15.

Source files
------------

// File: rtl/temporal_spike_encoder_if.sv
// Producer-side handshake bundle for the temporal spike encoder:
// one input vector (spike time plus null mask per input) with valid/ready.
interface temporal_spike_encoder_if #(
  parameter int INP  = 16,
  parameter int VRES = 3
);
  logic [INP-1:0][VRES-1:0] in_data;
  logic [INP-1:0]           in_mask;
  logic                     in_valid;
  logic                     in_ready;

  modport master (
    output in_data,
    output in_mask,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_mask,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/temporal_spike_encoder.sv
// Temporal spike encoder: buffers one input vector and, on each gamma pulse, emits
// one 2^WRES-cycle pulse per unmasked input starting v cycles into the wave.
module temporal_spike_encoder #(
  parameter int INP  = 16,
  parameter int VRES = 3,
  parameter int WRES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    grst,
  temporal_spike_encoder_if.slave in_bus,
  output logic [INP-1:0]          spikes,
  output logic                    busy,
  output logic                    underflow
);
  localparam int CW = VRES + WRES + 1;
  localparam logic [CW-1:0] PULSE_W = CW'(2 ** WRES);
  localparam logic [CW-1:0] T_LAST  = CW'((2 ** VRES) + (2 ** WRES) - 2);
  localparam logic [CW-1:0] T_ONE   = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [INP-1:0][VRES-1:0] vec_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  t_r, t_s;
  vec_t           buf_data_r, buf_data_s;
  logic [INP-1:0] buf_mask_r, buf_mask_s;
  logic           buf_full_r, buf_full_s;
  vec_t           act_data_r, act_data_s;
  logic [INP-1:0] act_mask_r, act_mask_s;
  logic [INP-1:0] spikes_r, spikes_s;
  logic           busy_r;
  logic           underflow_r, underflow_s;
  logic           accept_s;

  // A pulse covers wave times [v, v + 2^WRES); the sum cannot overflow CW bits.
  function automatic logic pulse_on(input logic [CW-1:0] t, input logic [VRES-1:0] v);
    logic [CW-1:0] start;
    start = {{(CW - VRES){1'b0}}, v};
    return (t >= start) && (t < (start + PULSE_W));
  endfunction

  // Ready depends only on the buffer register and reset, never on grst or in_valid.
  assign in_bus.in_ready = !buf_full_r && !rst;

  // Next-state: gamma start/abort, wave counting, buffer capture and spike decode.
  always_comb begin
    state_s     = state_r;
    t_s         = t_r;
    act_data_s  = act_data_r;
    act_mask_s  = act_mask_r;
    underflow_s = 1'b0;
    spikes_s    = {INP{1'b0}};

    if (grst) begin
      if (buf_full_r) begin
        state_s    = RUN;
        t_s        = {CW{1'b0}};
        act_data_s = buf_data_r;
        act_mask_s = buf_mask_r;
      end else begin
        state_s     = IDLE;
        act_mask_s  = {INP{1'b0}};
        underflow_s = 1'b1;
      end
    end else if (state_r == RUN) begin
      if (t_r == T_LAST) begin
        state_s = IDLE;
      end else begin
        t_s = t_r + T_ONE;
      end
    end else begin
      state_s = IDLE;
    end

    // A vector accepted alongside grst is kept for the following wave.
    accept_s   = in_bus.in_valid && !buf_full_r;
    buf_data_s = accept_s ? in_bus.in_data : buf_data_r;
    buf_mask_s = accept_s ? in_bus.in_mask : buf_mask_r;
    buf_full_s = (buf_full_r && !grst) || accept_s;

    for (int i = 0; i < INP; i++) begin
      spikes_s[i] = (state_s == RUN) && act_mask_s[i] && pulse_on(t_s, act_data_s[i]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      t_r         <= {CW{1'b0}};
      buf_data_r  <= {(INP * VRES){1'b0}};
      buf_mask_r  <= {INP{1'b0}};
      buf_full_r  <= 1'b0;
      act_data_r  <= {(INP * VRES){1'b0}};
      act_mask_r  <= {INP{1'b0}};
      spikes_r    <= {INP{1'b0}};
      busy_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      t_r         <= t_s;
      buf_data_r  <= buf_data_s;
      buf_mask_r  <= buf_mask_s;
      buf_full_r  <= buf_full_s;
      act_data_r  <= act_data_s;
      act_mask_r  <= act_mask_s;
      spikes_r    <= spikes_s;
      busy_r      <= (state_s == RUN);
      underflow_r <= underflow_s;
    end
  end

  assign spikes    = spikes_r;
  assign busy      = busy_r;
  assign underflow = underflow_r;
endmodule

// File: tb/tb_temporal_spike_encoder.sv
// Scoreboard bench for temporal_spike_encoder (INP=4, VRES=3, WRES=3): stimulus pushes
// per-cycle expected outputs from hand-computed windows; a negedge monitor pops and compares.
module tb_temporal_spike_encoder;
  logic       clk;
  logic       rst;
  logic       grst;
  logic [3:0] spikes;
  logic       busy;
  logic       underflow;

  temporal_spike_encoder_if #(.INP(4), .VRES(3)) bus ();

  temporal_spike_encoder #(.INP(4), .VRES(3), .WRES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .grst      (grst),
    .in_bus    (bus),
    .spikes    (spikes),
    .busy      (busy),
    .underflow (underflow)
  );

  typedef struct {
    int         tn;
    int         c;
    logic [3:0] sp;
    logic       bz;
    logic       uf;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  int   test_id;
  int   cyc;
  int   lo[4][2];
  int   hi[4][2];
  int   b_lo, b_hi, uf_a, uf_b;
  logic exp_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][2:0] pack(int v0, int v1, int v2, int v3);
    logic [3:0][2:0] p;
    p[0] = 3'(v0);
    p[1] = 3'(v1);
    p[2] = 3'(v2);
    p[3] = 3'(v3);
    return p;
  endfunction

  function automatic logic in_win(int i, int c);
    return ((c >= lo[i][0]) && (c <= hi[i][0])) || ((c >= lo[i][1]) && (c <= hi[i][1]));
  endfunction

  task automatic set_win(int i, int seg, int l, int h);
    lo[i][seg] = l;
    hi[i][seg] = h;
  endtask

  task automatic tick();
    exp_t e;
    e.tn = test_id;
    e.c  = cyc;
    for (int i = 0; i < 4; i++) e.sp[i] = in_win(i, cyc);
    e.bz  = (cyc >= b_lo) && (cyc <= b_hi);
    e.uf  = (cyc == uf_a) || (cyc == uf_b);
    e.rdy = exp_ready;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_until(int n);
    while (cyc < n) tick();
  endtask

  task automatic gamma();
    grst = 1'b1;
    tick();
    grst = 1'b0;
  endtask

  task automatic load(logic [3:0][2:0] d, logic [3:0] m);
    bus.in_data  = d;
    bus.in_mask  = m;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Every test opens with a two-cycle reset; cycle numbers are relative to it.
  task automatic begin_test(int id);
    test_id = id;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 2; s++) begin
        lo[i][s] = 1000;
        hi[i][s] = -1;
      end
    end
    b_lo = 1000; b_hi = -1; uf_a = -1; uf_b = -1;
    rst = 1'b1;
    exp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic check(string nm, int tn, int c, logic [3:0] act, logic [3:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL test%0d cycle%0d %s: got %b expected %b", tn, c, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("spikes",    mon_e.tn, mon_e.c, spikes, mon_e.sp);
      check("busy",      mon_e.tn, mon_e.c, {3'b000, busy}, {3'b000, mon_e.bz});
      check("underflow", mon_e.tn, mon_e.c, {3'b000, underflow}, {3'b000, mon_e.uf});
      check("in_ready",  mon_e.tn, mon_e.c, {3'b000, bus.in_ready}, {3'b000, mon_e.rdy});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    grst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = pack(0, 0, 0, 0);
    bus.in_mask  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a vector offered: nothing may be stored.
    bus.in_data  = pack(1, 2, 3, 4);
    bus.in_mask  = 4'b1111;
    bus.in_valid = 1'b1;
    begin_test(1);
    bus.in_valid = 1'b0;
    uf_a = 4;
    idle_until(3);
    gamma();
    idle_until(7);

    // Basic wave, values {0,3,7,5}, all inputs enabled.
    begin_test(2);
    set_win(0, 0, 11, 18); set_win(1, 0, 14, 21);
    set_win(2, 0, 18, 25); set_win(3, 0, 16, 23);
    b_lo = 11; b_hi = 25;
    idle_until(5);
    load(pack(0, 3, 7, 5), 4'b1111);
    exp_ready = 1'b0;
    idle_until(10);
    gamma();
    exp_ready = 1'b1;
    idle_until(28);

    // Same values, mask 1010.
    begin_test(3);
    set_win(1, 0, 14, 21); set_win(3, 0, 16, 23);
    b_lo = 11; b_hi = 25;
    idle_until(5);
    load(pack(0, 3, 7, 5), 4'b1010);
    exp_ready = 1'b0;
    idle_until(10);
    gamma();
    exp_ready = 1'b1;
    idle_until(28);

    // Underflow on empty buffer, then grst coincident with a transfer.
    begin_test(4);
    uf_a = 6; uf_b = 10;
    set_win(0, 0, 16, 23); set_win(1, 0, 15, 22);
    set_win(2, 0, 17, 24); set_win(3, 0, 21, 28);
    b_lo = 15; b_hi = 29;
    idle_until(5);
    gamma();
    idle_until(9);
    grst = 1'b1;
    bus.in_data  = pack(1, 0, 2, 6);
    bus.in_mask  = 4'b1111;
    bus.in_valid = 1'b1;
    tick();
    grst = 1'b0;
    bus.in_valid = 1'b0;
    exp_ready = 1'b0;
    idle_until(14);
    gamma();
    exp_ready = 1'b1;
    idle_until(31);

    // Abort at 15: old wave {0,3,7,5} cut off, new wave {0,2,1,4} mask 1101.
    begin_test(5);
    set_win(0, 0, 11, 15); set_win(1, 0, 14, 15);
    set_win(0, 1, 16, 23); set_win(2, 1, 17, 24); set_win(3, 1, 20, 27);
    b_lo = 11; b_hi = 30;
    idle_until(5);
    load(pack(0, 3, 7, 5), 4'b1111);
    exp_ready = 1'b0;
    idle_until(10);
    gamma();
    exp_ready = 1'b1;
    idle_until(12);
    load(pack(0, 2, 1, 4), 4'b1101);
    exp_ready = 1'b0;
    idle_until(15);
    gamma();
    exp_ready = 1'b1;
    idle_until(32);

    // Backpressure with in_valid held, then rst at 14 mid-wave clears everything.
    begin_test(6);
    set_win(0, 0, 11, 14); set_win(1, 0, 14, 14);
    b_lo = 11; b_hi = 14;
    uf_a = 18;
    idle_until(5);
    bus.in_data  = pack(0, 3, 7, 5);
    bus.in_mask  = 4'b1111;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data  = pack(0, 2, 1, 4);
    bus.in_mask  = 4'b1101;
    exp_ready = 1'b0;
    idle_until(10);
    gamma();
    exp_ready = 1'b1;
    tick();
    exp_ready = 1'b0;
    idle_until(14);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ready = 1'b1;
    idle_until(17);
    gamma();
    idle_until(21);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
